bcd_seven_seg_display: RTL and testbench
========================================

Name: bcd_seven_seg_display

Overview:
Parametrised successor to the team's fixed 4-digit, 12-bit decimal seven-segment driver. It converts an unsigned binary value to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per clock, instead of combinational divide/modulo. It supports any digit count, leading-zero blanking, an overflow indication and selectable segment polarity. It sits between counters/score logic and the board's seven-segment pins.

Parameters:
BIN_W, 12, width of the binary input; legal range 4..31.
DIGITS, 4, number of decimal digits driven; legal range 1..8.
ACTIVE_LOW, 1, 1 means a segment is lit by driving 0; 0 means a segment is lit by driving 1.
BLANK_LZ, 1, 1 blanks leading zero digits; 0 shows all digits.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
load  input  1  single-cycle request to convert and display number
number  input  BIN_W  unsigned value to display, sampled on the load cycle
busy  output  1  conversion in progress
seg  output  7*DIGITS  segments; seg[6:0] is the units digit, seg[7k+6:7k] is digit k; bit order is g..a (bit 6 = g)
overflow  output  1  displayed value is at least 10**DIGITS

Behaviour:
- Reset (rst low, asynchronous): state IDLE; busy=0; overflow=0; pending flag cleared; seg = all digits blank (every segment unlit, i.e. all 1s when ACTIVE_LOW=1).
- FSM states:
  - IDLE: on load=1, capture number into the shift register, clear the BCD accumulator (4*DIGITS bits), set bit counter = BIN_W, go to SHIFT.
  - SHIFT: each cycle, first add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 and decrement the counter. After the BIN_W-th shift, go to UPDATE.
  - UPDATE: one cycle; register seg and overflow from the completed BCD, then go to IDLE. If the pending flag is set, go to SHIFT with the pending value instead and clear pending.
- busy=1 in SHIFT and UPDATE.
- Latency: load sampled at edge T; seg and overflow change at edge T+BIN_W+1, and all digits change on the same edge (no partially updated display).
- load while busy: number is stored in a one-deep pending register; the last request wins. It is serviced directly after the current UPDATE with no IDLE cycle. Simultaneous load and UPDATE follows the same rule.
- Overflow: set when the captured value >= 10**DIGITS, compared at capture against a constant of BIN_W+1 bits. When set, every digit shows a dash (segment g only) and overflow=1 until the next UPDATE. If 10**DIGITS > 2**BIN_W - 1, overflow is tied to 0.
- Blanking (BLANK_LZ=1): digits above the most significant non-zero digit are blank. Value 0 shows "0" in digit 0 only. Digit 0 is never blanked.
- Polarity: patterns are defined active-high internally and inverted at the output register when ACTIVE_LOW=1.
- Reset mid-conversion: the conversion and any pending request are abandoned and the outputs return to their reset values.
- seg, busy and overflow are all registered; no combinational path from inputs to outputs.

Decomposition:
- Package bcd_seg_pkg holds:
  - the digit-to-pattern function for 0-9, active-high, g..a;
  - constants SEG_BLANK (7'b0000000) and SEG_DASH (7'b1000000);
  - the FSM state enum (IDLE, SHIFT, UPDATE);
  - a constant function pow10(n) used for the overflow threshold.
- One sub-module, seg_digit_encode: combinational; inputs are a 4-bit digit, blank and dash; output is 7 bits; instantiated DIGITS times by a generate loop.
- The FSM, double-dabble datapath and output registers stay in the top level.

Test Plan:
- Defaults: load number=0 → after 13 cycles, seg digit0="0" pattern, digits 1-3 blank, overflow=0, busy low on the cycle after UPDATE.
- Defaults: load 1234, then later load 4095 → digits "1","2","3","4", then "4","0","9","5"; verify busy high for exactly 13 cycles per load and all digits update on one edge.
- BIN_W=14, DIGITS=4: load 9999 → "9999", overflow=0; load 10000 → all four digits show dash (g only), overflow=1; load 7 → overflow clears, "   7".
- Defaults: load 42, then load 305 three cycles later, then load 88 at cycle 5 → display shows "42", then "88" (305 dropped); second conversion starts with no IDLE gap.
- ACTIVE_LOW=0, BLANK_LZ=0, load 5 → seg = {0x3F,0x3F,0x3F,0x6D} (active-high, g..a), i.e. "0005".
- Load 999, drop rst at cycle 6 of SHIFT → seg immediately all-blank, busy=0, overflow=0. Release rst and load 12 → "  12" after 13 cycles with no stale pending value.

Source files
------------

// File: rtl/bcd_seg_pkg.sv
// rtl/bcd_seg_pkg.sv - shared types, segment patterns and helpers for the BCD seven-segment driver
//
// Purpose: FSM state type, segment pattern constants, digit-to-pattern
//          lookup and the pow10 constant function used for the overflow
//          threshold.
// Contents:
//   state_t      : IDLE, SHIFT, UPDATE
//   SEG_BLANK    : all segments unlit (active-high)
//   SEG_DASH     : segment g only (active-high)
//   digit_to_seg : 4-bit digit -> 7-bit pattern g..a, active-high
//   pow10        : 10**n as a 64-bit constant

package bcd_seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  // Bit 6 = g ... bit 0 = a. Codes 10-15 cannot come out of a valid BCD
  // conversion and are shown blank.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_digit_encode.sv
// rtl/seg_digit_encode.sv - one digit of BCD to seven-segment pattern, active-high
//
// Purpose: combinational encoder for a single display digit.
// Ports:
//   digit : in  4  BCD digit 0-9
//   blank : in  1  show nothing (leading-zero blanking)
//   dash  : in  1  show segment g only (overflow); wins over blank
//   seg   : out 7  active-high pattern, bit 6 = g ... bit 0 = a

module seg_digit_encode
  import bcd_seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      seg = digit_to_seg(digit);
    end
  end

endmodule

// File: rtl/bcd_seven_seg_display.sv
// rtl/bcd_seven_seg_display.sv - binary to multi-digit seven-segment driver using sequential double-dabble
//
// Purpose: converts an unsigned binary value to BCD one bit per clock and
//          drives DIGITS seven-segment digits, with leading-zero blanking,
//          overflow dashes and selectable segment polarity.
// Ports:
//   clk      : in  1         system clock
//   rst      : in  1         asynchronous, active-low reset
//   load     : in  1         single-cycle convert request
//   number   : in  BIN_W     value sampled on the load cycle
//   busy     : out 1         high in SHIFT and UPDATE
//   seg      : out 7*DIGITS  seg[7k+6:7k] is digit k (k=0 units), bits g..a
//   overflow : out 1         displayed value >= 10**DIGITS

module bcd_seven_seg_display
  import bcd_seg_pkg::*;
#(
  parameter int BIN_W      = 12,
  parameter int DIGITS     = 4,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BIN_W-1:0]      number,
  output logic                  busy,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [63:0] THRESH64 = pow10(DIGITS);
  localparam logic [63:0] MAX_IN   = (64'd1 << BIN_W) - 64'd1;
  // When every representable input fits on the display, overflow can never occur.
  localparam bit          OVF_EN   = (THRESH64 <= MAX_IN);
  localparam logic [BIN_W:0] THRESH = THRESH64[BIN_W:0];

  // XOR mask applied at the output register: all ones inverts for active-low pins.
  localparam logic [7*DIGITS-1:0] SEG_OFF = {(7 * DIGITS){ACTIVE_LOW}};

  state_t             state;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               pend_valid;
  logic [BIN_W-1:0]   pend_num;

  logic [BCD_W-1:0]    bcd_adj;
  logic                start_now;
  logic [BIN_W-1:0]    start_num;
  logic                ovf_start;
  logic [7*DIGITS-1:0] pat;

  // Add-3 correction before each shift so every nibble stays a decimal digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // A load arriving in UPDATE is the newest request, so it beats a stored pending one.
  always_comb begin
    start_now = 1'b0;
    start_num = number;
    case (state)
      IDLE: begin
        start_now = load;
        start_num = number;
      end
      UPDATE: begin
        start_now = load | pend_valid;
        start_num = load ? number : pend_num;
      end
      default: begin
        start_now = 1'b0;
        start_num = number;
      end
    endcase
  end

  assign ovf_start = OVF_EN && ({1'b0, start_num} >= THRESH);

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic blank;
    if (k == 0) begin : g_units
      assign blank = 1'b0;
    end else begin : g_upper
      // Blank when this digit and everything above it is zero.
      assign blank = BLANK_LZ && (bcd_q[BCD_W-1:4*k] == '0);
    end
    seg_digit_encode u_enc (
      .digit (bcd_q[4*k +: 4]),
      .blank (blank),
      .dash  (ovf_q),
      .seg   (pat[7*k +: 7])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      seg        <= SEG_OFF;
      overflow   <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pend_valid <= 1'b0;
      pend_num   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_now) begin
            bin_q <= start_num;
            bcd_q <= '0;
            cnt_q <= CNT_W'(BIN_W);
            ovf_q <= ovf_start;
            state <= SHIFT;
            busy  <= 1'b1;
          end
        end

        SHIFT: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state <= UPDATE;
          end
          if (load) begin
            pend_valid <= 1'b1;
            pend_num   <= number;
          end
        end

        UPDATE: begin
          seg        <= pat ^ SEG_OFF;
          overflow   <= ovf_q;
          pend_valid <= 1'b0;
          if (start_now) begin
            bin_q <= start_num;
            bcd_q <= '0;
            cnt_q <= CNT_W'(BIN_W);
            ovf_q <= ovf_start;
            state <= SHIFT;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seven_seg_display.sv
// tb/tb_bcd_seven_seg_display.sv - self-checking bench for bcd_seven_seg_display

module tb_bcd_seven_seg_display;

  localparam int BW  [3] = '{12, 14, 12};
  localparam bit AL  [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit BLZ [3] = '{1'b1, 1'b1, 1'b0};
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic        clk = 1'b0;
  logic        rst;
  logic        load    [3];
  logic [11:0] num0;
  logic [13:0] num1;
  logic [11:0] num2;
  logic        busy_w  [3];
  logic [27:0] seg_w   [3];
  logic        ovf_w   [3];

  always #5 clk = ~clk;

  bcd_seven_seg_display #(.BIN_W(12), .DIGITS(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load[0]), .number(num0),
    .busy(busy_w[0]), .seg(seg_w[0]), .overflow(ovf_w[0]));

  bcd_seven_seg_display #(.BIN_W(14), .DIGITS(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut14 (
    .clk(clk), .rst(rst), .load(load[1]), .number(num1),
    .busy(busy_w[1]), .seg(seg_w[1]), .overflow(ovf_w[1]));

  bcd_seven_seg_display #(.BIN_W(12), .DIGITS(4), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut_ah (
    .clk(clk), .rst(rst), .load(load[2]), .number(num2),
    .busy(busy_w[2]), .seg(seg_w[2]), .overflow(ovf_w[2]));

  typedef struct {
    logic [27:0] seg;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;

  logic [27:0] prev_seg  [3];
  logic        prev_busy [3];
  logic        prev_ovf  [3];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      prev_seg[i]  <= seg_w[i];
      prev_busy[i] <= busy_w[i];
      prev_ovf[i]  <= ovf_w[i];
    end
  end

  // Reference: decimal digits by divide/modulo, expected display for a 4-digit instance.
  function automatic logic [27:0] model_seg(input int v, input int bw, input bit al,
                                            input bit blz, output bit ovf);
    int         d [4];
    int         tmp;
    int         msd;
    bit         en;
    logic [6:0] p;
    logic [27:0] r;
    en  = (10000 <= ((1 << bw) - 1));
    ovf = en && (v >= 10000);
    tmp = v;
    for (int k = 0; k < 4; k++) begin
      d[k] = tmp % 10;
      tmp  = tmp / 10;
    end
    msd = 0;
    for (int k = 0; k < 4; k++) if (d[k] != 0) msd = k;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (ovf) p = 7'h40;
      else if (blz && k > msd) p = 7'h00;
      else p = PAT[d[k]];
      r[7*k +: 7] = al ? ~p : p;
    end
    return r;
  endfunction

  // Output event: display changed, or busy fell (an UPDATE completed).
  function automatic bit evt(input int i);
    return (seg_w[i] !== prev_seg[i]) || (ovf_w[i] !== prev_ovf[i]) ||
           (prev_busy[i] === 1'b1 && busy_w[i] === 1'b0);
  endfunction

  task automatic set_num(input int idx, input int v);
    case (idx)
      0:       num0 = v[11:0];
      1:       num1 = v[13:0];
      default: num2 = v[11:0];
    endcase
  endtask

  task automatic push_exp(input int idx, input int v);
    logic [27:0] m;
    bit          mo;
    m = model_seg(v, BW[idx], AL[idx], BLZ[idx], mo);
    exp_q.push_back('{seg: m, ovf: mo});
  endtask

  task automatic wait_evt(input int idx, input int budget, output bit got,
                          output int ecyc, output int bcnt);
    got  = 1'b0;
    ecyc = 0;
    bcnt = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (busy_w[idx] === 1'b1) bcnt++;
      if (evt(idx)) begin
        got  = 1'b1;
        ecyc = cyc;
        break;
      end
    end
  endtask

  // Single load; returns observed display, latency from sampling edge and busy length.
  task automatic convert(input int idx, input int v, output bit got, output logic [27:0] s,
                         output logic o, output int lat, output int bcnt);
    int t_samp;
    int ecyc;
    @(posedge clk); #1;
    load[idx] = 1'b1;
    set_num(idx, v);
    t_samp = cyc + 1;
    push_exp(idx, v);
    @(posedge clk); #1;
    load[idx] = 1'b0;
    wait_evt(idx, 40, got, ecyc, bcnt);
    lat = ecyc - t_samp;
    s   = seg_w[idx];
    o   = ovf_w[idx];
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (seg_w[0] !== 28'hFFFFFFF) $display("FAIL reset_seg0: got %h expected %h", seg_w[0], 28'hFFFFFFF); else pass_cnt++;
    total_cnt++; if (busy_w[0] !== 1'b0) $display("FAIL reset_busy0: got %b expected 0", busy_w[0]); else pass_cnt++;
    total_cnt++; if (ovf_w[0] !== 1'b0) $display("FAIL reset_ovf0: got %b expected 0", ovf_w[0]); else pass_cnt++;
    total_cnt++; if (seg_w[2] !== 28'h0000000) $display("FAIL reset_seg_active_high: got %h expected 0000000", seg_w[2]); else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (seg_w[1] !== 28'hFFFFFFF || busy_w[1] !== 1'b0) $display("FAIL reset_dut14: got seg %h busy %b expected FFFFFFF 0", seg_w[1], busy_w[1]); else pass_cnt++;
  endtask

  task automatic test_zero;
    bit got; logic [27:0] s; logic o; int lat; int bcnt; exp_t e;
    convert(0, 0, got, s, o, lat, bcnt);
    e = exp_q.pop_front();
    total_cnt++; if (!got) $display("FAIL zero_timeout: no update seen expected update"); else pass_cnt++;
    total_cnt++; if (s !== e.seg) $display("FAIL zero_seg: got %h expected %h", s, e.seg); else pass_cnt++;
    total_cnt++; if (s !== 28'hFFFFFC0) $display("FAIL zero_seg_const: got %h expected FFFFFC0", s); else pass_cnt++;
    total_cnt++; if (o !== e.ovf) $display("FAIL zero_ovf: got %b expected %b", o, e.ovf); else pass_cnt++;
    total_cnt++; if (lat !== 13) $display("FAIL zero_latency: got %0d expected 13", lat); else pass_cnt++;
    total_cnt++; if (bcnt !== 13) $display("FAIL zero_busy_len: got %0d expected 13", bcnt); else pass_cnt++;
  endtask

  task automatic test_values;
    int vals [2] = '{1234, 4095};
    bit got; logic [27:0] s; logic o; int lat; int bcnt; exp_t e;
    for (int i = 0; i < 2; i++) begin
      repeat (3) @(posedge clk);
      convert(0, vals[i], got, s, o, lat, bcnt);
      e = exp_q.pop_front();
      total_cnt++; if (!got) $display("FAIL values_timeout[%0d]: no update seen expected update", vals[i]); else pass_cnt++;
      total_cnt++; if (s !== e.seg) $display("FAIL values_seg[%0d]: got %h expected %h", vals[i], s, e.seg); else pass_cnt++;
      total_cnt++; if (o !== e.ovf) $display("FAIL values_ovf[%0d]: got %b expected %b", vals[i], o, e.ovf); else pass_cnt++;
      total_cnt++; if (lat !== 13) $display("FAIL values_latency[%0d]: got %0d expected 13", vals[i], lat); else pass_cnt++;
      total_cnt++; if (bcnt !== 13) $display("FAIL values_busy_len[%0d]: got %0d expected 13", vals[i], bcnt); else pass_cnt++;
    end
  endtask

  task automatic test_overflow;
    int vals [3] = '{9999, 10000, 7};
    logic [27:0] dash_all;
    bit got; logic [27:0] s; logic o; int lat; int bcnt; exp_t e;
    dash_all = ~{4{7'h40}};
    for (int i = 0; i < 3; i++) begin
      convert(1, vals[i], got, s, o, lat, bcnt);
      e = exp_q.pop_front();
      total_cnt++; if (!got) $display("FAIL ovf_timeout[%0d]: no update seen expected update", vals[i]); else pass_cnt++;
      total_cnt++; if (s !== e.seg) $display("FAIL ovf_seg[%0d]: got %h expected %h", vals[i], s, e.seg); else pass_cnt++;
      total_cnt++; if (o !== e.ovf) $display("FAIL ovf_flag[%0d]: got %b expected %b", vals[i], o, e.ovf); else pass_cnt++;
      total_cnt++; if (lat !== 15) $display("FAIL ovf_latency[%0d]: got %0d expected 15", vals[i], lat); else pass_cnt++;
      if (vals[i] == 10000) begin
        total_cnt++; if (s !== dash_all || o !== 1'b1) $display("FAIL ovf_dash_const: got %h/%b expected %h/1", s, o, dash_all); else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back;
    int t_samp = 0; int ecyc; int bcnt; bit got; logic b1; exp_t e;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      load[0] = 1'b0;
      if (k == 0) begin
        load[0] = 1'b1; set_num(0, 42); t_samp = cyc + 1; push_exp(0, 42);
      end else if (k == 3) begin
        load[0] = 1'b1; set_num(0, 305); push_exp(0, 305);
      end else if (k == 5) begin
        // Last request while busy wins: 88 replaces the still-pending 305.
        load[0] = 1'b1; set_num(0, 88);
        void'(exp_q.pop_back()); push_exp(0, 88);
      end
    end
    @(posedge clk); #1;
    load[0] = 1'b0;
    wait_evt(0, 40, got, ecyc, bcnt);
    b1 = busy_w[0];
    e = exp_q.pop_front();
    total_cnt++; if (!got) $display("FAIL b2b_first_timeout: no update seen expected update"); else pass_cnt++;
    total_cnt++; if (ecyc !== t_samp + 13) $display("FAIL b2b_first_edge: got %0d expected %0d", ecyc, t_samp + 13); else pass_cnt++;
    total_cnt++; if (seg_w[0] !== e.seg) $display("FAIL b2b_first_seg: got %h expected %h", seg_w[0], e.seg); else pass_cnt++;
    total_cnt++; if (b1 !== 1'b1) $display("FAIL b2b_no_idle_gap: got busy %b expected 1", b1); else pass_cnt++;
    wait_evt(0, 40, got, ecyc, bcnt);
    e = exp_q.pop_front();
    total_cnt++; if (!got) $display("FAIL b2b_second_timeout: no update seen expected update"); else pass_cnt++;
    total_cnt++; if (ecyc !== t_samp + 26) $display("FAIL b2b_second_edge: got %0d expected %0d", ecyc, t_samp + 26); else pass_cnt++;
    total_cnt++; if (seg_w[0] !== e.seg) $display("FAIL b2b_second_seg: got %h expected %h", seg_w[0], e.seg); else pass_cnt++;
    wait_evt(0, 20, got, ecyc, bcnt);
    total_cnt++; if (got) $display("FAIL b2b_extra_update: got update at cycle %0d expected none", ecyc); else pass_cnt++;
  endtask

  task automatic test_polarity;
    bit got; logic [27:0] s; logic o; int lat; int bcnt; exp_t e;
    logic [27:0] want;
    want = {7'h3F, 7'h3F, 7'h3F, 7'h6D};
    convert(2, 5, got, s, o, lat, bcnt);
    e = exp_q.pop_front();
    total_cnt++; if (!got) $display("FAIL pol_timeout: no update seen expected update"); else pass_cnt++;
    total_cnt++; if (s !== e.seg) $display("FAIL pol_seg: got %h expected %h", s, e.seg); else pass_cnt++;
    total_cnt++; if (s !== want) $display("FAIL pol_seg_const: got %h expected %h", s, want); else pass_cnt++;
    total_cnt++; if (o !== 1'b0) $display("FAIL pol_ovf: got %b expected 0", o); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bit got; logic [27:0] s; logic o; int lat; int bcnt; int ecyc; exp_t e;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      load[0] = 1'b0;
      if (k == 0) begin load[0] = 1'b1; set_num(0, 999); end
      else if (k == 2) begin load[0] = 1'b1; set_num(0, 305); end
    end
    #3;
    rst = 1'b0;
    exp_q.delete();
    #1;
    total_cnt++; if (seg_w[0] !== 28'hFFFFFFF) $display("FAIL rstmid_seg: got %h expected FFFFFFF", seg_w[0]); else pass_cnt++;
    total_cnt++; if (busy_w[0] !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy_w[0]); else pass_cnt++;
    total_cnt++; if (ovf_w[0] !== 1'b0) $display("FAIL rstmid_ovf: got %b expected 0", ovf_w[0]); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b1;
    convert(0, 12, got, s, o, lat, bcnt);
    e = exp_q.pop_front();
    total_cnt++; if (!got) $display("FAIL rstmid_timeout: no update seen expected update"); else pass_cnt++;
    total_cnt++; if (s !== e.seg) $display("FAIL rstmid_seg12: got %h expected %h", s, e.seg); else pass_cnt++;
    total_cnt++; if (lat !== 13) $display("FAIL rstmid_latency: got %0d expected 13", lat); else pass_cnt++;
    wait_evt(0, 30, got, ecyc, bcnt);
    total_cnt++; if (got || bcnt != 0) $display("FAIL rstmid_stale_pending: got update %b busy cycles %0d expected 0 0", got, bcnt); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) load[i] = 1'b0;
    num0 = '0;
    num1 = '0;
    num2 = '0;
    test_reset();
    test_zero();
    test_values();
    test_overflow();
    test_back_to_back();
    test_polarity();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

endmodule
